// File: rtl/pt_serial_feeder.sv
// Byte FIFO feeding a two-lane serial plaintext shifter, with a small
// IDLE/LOCK/RUN controller that loads key, nonce and counter init into the encrypter.
module pt_serial_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_start,
    input  logic [7:0] cfg_key,
    input  logic [1:0] cfg_nonce,
    input  logic [1:0] cfg_init,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] key,
    output logic [1:0] nonce,
    output logic [1:0] init_value,
    output logic       lock,
    output logic       plain_text_input1,
    output logic       plain_text_input2,
    output logic       pt_valid,
    output logic       busy,
    output logic [7:0] byte_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fill;

    logic [7:0]       shift_reg;
    logic [1:0]       pair_idx;
    logic             shifting;
    logic             shifting_next;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             last_pair;

    assign full      = (fill == (PTR_W+1)'(FIFO_DEPTH));
    assign empty     = (fill == '0);
    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign last_pair = shifting & (pair_idx == 2'd3);
    // Popping on the last pair keeps consecutive bytes gap-free on the lanes.
    assign pop       = (state == RUN) & ~empty & (~shifting | last_pair);

    always_comb begin
        state_next    = state;
        shifting_next = shifting;
        if (pop) begin
            shifting_next = 1'b1;
        end else if (last_pair) begin
            shifting_next = 1'b0;
        end
        case (state)
            IDLE: if (cfg_start) state_next = LOCK;
            LOCK: state_next = RUN;
            RUN:  if (cfg_start && empty && !shifting) state_next = LOCK;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lock       <= 1'b0;
            key        <= '0;
            nonce      <= '0;
            init_value <= '0;
            busy       <= 1'b0;
        end else begin
            state <= state_next;
            lock  <= (state_next == LOCK);
            busy  <= (state_next != IDLE) | shifting_next;
            if (state_next == LOCK) begin
                key        <= cfg_key;
                nonce      <= cfg_nonce;
                init_value <= cfg_init;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (PTR_W+1)'(1);
                2'b01:   fill <= fill - (PTR_W+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // The top two bits of shift_reg drive the lanes; it is zeroed when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            pair_idx   <= '0;
            shifting   <= 1'b0;
            byte_count <= '0;
        end else begin
            if (last_pair) byte_count <= byte_count + 8'd1;
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                pair_idx  <= '0;
                shifting  <= 1'b1;
            end else if (last_pair) begin
                shift_reg <= '0;
                pair_idx  <= '0;
                shifting  <= 1'b0;
            end else if (shifting) begin
                shift_reg <= {shift_reg[5:0], 2'b00};
                pair_idx  <= pair_idx + 2'd1;
            end
        end
    end

    assign pt_valid          = shifting;
    assign plain_text_input1 = shift_reg[7];
    assign plain_text_input2 = shift_reg[6];

endmodule

// File: tb/tb_pt_serial_feeder.sv
// Self-checking bench for pt_serial_feeder: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_pt_serial_feeder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_start;
    logic [7:0] cfg_key;
    logic [1:0] cfg_nonce;
    logic [1:0] cfg_init;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] key;
    logic [1:0] nonce;
    logic [1:0] init_value;
    logic       lock;
    logic       plain_text_input1;
    logic       plain_text_input2;
    logic       pt_valid;
    logic       busy;
    logic [7:0] byte_count;

    int checks   = 0;
    int failures = 0;

    pt_serial_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_key           (cfg_key),
        .cfg_nonce         (cfg_nonce),
        .cfg_init          (cfg_init),
        .in_byte           (in_byte),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .key               (key),
        .nonce             (nonce),
        .init_value        (init_value),
        .lock              (lock),
        .plain_text_input1 (plain_text_input1),
        .plain_text_input2 (plain_text_input2),
        .pt_valid          (pt_valid),
        .busy              (busy),
        .byte_count        (byte_count)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the byte currently on the lanes.
    typedef enum int {M_IDLE, M_LOCK, M_RUN} mstate_t;
    mstate_t    m_state;
    logic [7:0] m_q[$];
    logic [7:0] m_cur;
    int         m_k;
    int         m_count;
    logic [7:0] m_key;
    logic [1:0] m_nonce;
    logic [1:0] m_init;

    task automatic model_clear();
        m_state = M_IDLE;
        m_q.delete();
        m_cur   = 8'h00;
        m_k     = -1;
        m_count = 0;
        m_key   = 8'h00;
        m_nonce = 2'b00;
        m_init  = 2'b00;
    endtask

    function automatic logic exp_lane(input int lane);
        logic [7:0] b;
        b = m_cur;
        if (m_k < 0) return 1'b0;
        return (lane == 1) ? b[7 - 2*m_k] : b[6 - 2*m_k];
    endfunction

    // Drives one cycle of inputs, advances the model across the edge, samples at edge+1.
    task automatic drive_cycle(input logic start, input logic [7:0] k, input logic [1:0] n,
                               input logic [1:0] iv, input logic valid, input logic [7:0] data);
        bit push, pop, relock_ok;
        cfg_start = start;
        cfg_key   = k;
        cfg_nonce = n;
        cfg_init  = iv;
        in_valid  = valid;
        in_byte   = data;
        push      = valid && (m_q.size() < DEPTH);
        pop       = (m_state == M_RUN) && (m_q.size() > 0) && (m_k < 0 || m_k == 3);
        relock_ok = (m_q.size() == 0) && (m_k < 0);
        if (m_k == 3) m_count = (m_count + 1) % 256;
        if (pop) begin
            m_cur = m_q.pop_front();
            m_k   = 0;
        end else if (m_k == 3) begin
            m_k = -1;
        end else if (m_k >= 0) begin
            m_k = m_k + 1;
        end
        if (push) m_q.push_back(data);
        case (m_state)
            M_IDLE: if (start) m_state = M_LOCK;
            M_LOCK: m_state = M_RUN;
            M_RUN:  if (start && relock_ok) m_state = M_LOCK;
            default: m_state = M_IDLE;
        endcase
        if (m_state == M_LOCK) begin
            m_key   = k;
            m_nonce = n;
            m_init  = iv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        reset     = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        cfg_start = 1'b0; cfg_key = 8'h00; cfg_nonce = 2'b00; cfg_init = 2'b00;
        in_valid  = 1'b0; in_byte = 8'h00;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({key, nonce, init_value, lock, plain_text_input1, plain_text_input2, pt_valid, busy, byte_count} !== 25'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got key=%h nonce=%b init=%b lock=%b l1=%b l2=%b v=%b busy=%b cnt=%0d expected all zero",
                     key, nonce, init_value, lock, plain_text_input1, plain_text_input2, pt_valid, busy, byte_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_config_load();
        drive_cycle(1'b1, 8'hDB, 2'b11, 2'b01, 1'b0, 8'h00);
        checks++;
        if ({lock, key, nonce, init_value} !== {1'b1, 8'hDB, 2'b11, 2'b01}) begin
            failures++;
            $display("[TB] FAIL cfg_lock got lock=%b key=%h nonce=%b init=%b expected 1 DB 11 01",
                     lock, key, nonce, init_value);
        end
        idle_cycle();
        checks++;
        if ({lock, key, nonce, init_value, busy} !== {1'b0, 8'hDB, 2'b11, 2'b01, 1'b1}) begin
            failures++;
            $display("[TB] FAIL cfg_hold got lock=%b key=%h nonce=%b init=%b busy=%b expected 0 DB 11 01 1",
                     lock, key, nonce, init_value, busy);
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] exp_pairs [4];
        exp_pairs[0] = 2'b10; exp_pairs[1] = 2'b10; exp_pairs[2] = 2'b01; exp_pairs[3] = 2'b01;
        drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, 8'hA5);
        checks++;
        if (pt_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_latency got pt_valid=%b expected 0", pt_valid);
        end
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            checks++;
            if ({pt_valid, plain_text_input1, plain_text_input2} !== {1'b1, exp_pairs[i]}) begin
                failures++;
                $display("[TB] FAIL single_pair%0d got v=%b pair=%b%b expected v=1 pair=%b",
                         i, pt_valid, plain_text_input1, plain_text_input2, exp_pairs[i]);
            end
        end
        idle_cycle();
        checks++;
        if ({pt_valid, plain_text_input1, plain_text_input2, byte_count} !== {3'b000, 8'd1}) begin
            failures++;
            $display("[TB] FAIL single_done got v=%b l1=%b l2=%b cnt=%0d expected 0 0 0 1",
                     pt_valid, plain_text_input1, plain_text_input2, byte_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        logic [7:0] b;
        logic [1:0] want;
        logic [7:0] base;
        bytes[0] = 8'hFF; bytes[1] = 8'h00; bytes[2] = 8'h3C;
        base = byte_count;
        drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, bytes[0]);
        for (int i = 0; i < 12; i++) begin
            if (i < 2) drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, bytes[i+1]);
            else       idle_cycle();
            b    = bytes[i/4];
            want = 2'((b >> (6 - 2*(i%4))) & 8'h03);
            checks++;
            if ({pt_valid, plain_text_input1, plain_text_input2} !== {1'b1, want}) begin
                failures++;
                $display("[TB] FAIL b2b_cycle%0d got v=%b pair=%b%b expected v=1 pair=%b",
                         i, pt_valid, plain_text_input1, plain_text_input2, want);
            end
        end
        idle_cycle();
        checks++;
        if ({pt_valid, byte_count} !== {1'b0, 8'(base + 8'd3)}) begin
            failures++;
            $display("[TB] FAIL b2b_done got v=%b cnt=%0d expected v=0 cnt=%0d", pt_valid, byte_count, base + 8'd3);
        end
    endtask

    task automatic test_relock();
        drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, 8'h5A);
        idle_cycle();
        drive_cycle(1'b1, 8'h11, 2'b01, 2'b10, 1'b0, 8'h00);
        checks++;
        if ({lock, key} !== {1'b0, 8'hDB}) begin
            failures++;
            $display("[TB] FAIL relock_ignored got lock=%b key=%h expected 0 DB", lock, key);
        end
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++;
            if (lock !== 1'b0) begin
                failures++;
                $display("[TB] FAIL relock_not_queued%0d got lock=%b expected 0", i, lock);
            end
        end
        drive_cycle(1'b1, 8'h11, 2'b01, 2'b10, 1'b0, 8'h00);
        checks++;
        if ({lock, key, nonce, init_value} !== {1'b1, 8'h11, 2'b01, 2'b10}) begin
            failures++;
            $display("[TB] FAIL relock_accepted got lock=%b key=%h nonce=%b init=%b expected 1 11 01 10",
                     lock, key, nonce, init_value);
        end
        idle_cycle();
        checks++;
        if (lock !== 1'b0) begin
            failures++;
            $display("[TB] FAIL relock_pulse_width got lock=%b expected 0", lock);
        end
    endtask

    task automatic test_full_backpressure();
        logic [7:0] bytes [5];
        logic [1:0] seen [$];
        logic [7:0] b;
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (in_ready !== (i < DEPTH)) begin
                failures++;
                $display("[TB] FAIL full_ready_before%0d got %b expected %b", i, in_ready, (i < DEPTH));
            end
            drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, bytes[i]);
        end
        drive_cycle(1'b1, 8'h77, 2'b10, 2'b11, 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) begin
            idle_cycle();
            if (pt_valid === 1'b1) seen.push_back({plain_text_input1, plain_text_input2});
        end
        checks++;
        if (seen.size() != 4 * DEPTH) begin
            failures++;
            $display("[TB] FAIL full_pair_count got %0d expected %0d", seen.size(), 4 * DEPTH);
        end
        for (int i = 0; i < 4 * DEPTH && i < seen.size(); i++) begin
            b    = bytes[i/4];
            want = 2'((b >> (6 - 2*(i%4))) & 8'h03);
            checks++;
            if (seen[i] !== want) begin
                failures++;
                $display("[TB] FAIL full_order_pair%0d got %b expected %b", i, seen[i], want);
            end
        end
        checks++;
        if (byte_count !== 8'd4) begin
            failures++;
            $display("[TB] FAIL full_byte_count got %0d expected 4", byte_count);
        end
    endtask

    task automatic test_reset_mid_byte();
        do_reset();
        drive_cycle(1'b1, 8'h42, 2'b01, 2'b01, 1'b0, 8'h00);
        idle_cycle();
        drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, 1'b1, 8'hC3);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        checks++;
        if ({pt_valid, plain_text_input1, plain_text_input2} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL midbyte_k2 got v=%b pair=%b%b expected v=1 pair=00",
                     pt_valid, plain_text_input1, plain_text_input2);
        end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({key, nonce, init_value, lock, plain_text_input1, plain_text_input2, pt_valid, busy, byte_count, in_ready} !== {25'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL midbyte_async_clear got key=%h lock=%b v=%b busy=%b cnt=%0d rdy=%b expected zeros rdy=1",
                     key, lock, pt_valid, busy, byte_count, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 8'h00, 2'b00, 2'b00, (i < 2), 8'($urandom));
            checks++;
            if ({pt_valid, plain_text_input1, plain_text_input2, lock, busy} !== 5'b00000) begin
                failures++;
                $display("[TB] FAIL midbyte_no_residual%0d got v=%b l1=%b l2=%b lock=%b busy=%b expected 0",
                         i, pt_valid, plain_text_input1, plain_text_input2, lock, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [25:0] act;
        logic [25:0] exp;
        int          valid_pct;
        do_reset();
        drive_cycle(1'b1, 8'($urandom), 2'($urandom), 2'($urandom), 1'b0, 8'h00);
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid_pct = (cyc % 150 < 75) ? 50 : 10;
            drive_cycle(($urandom_range(0, 19) == 0), 8'($urandom), 2'($urandom), 2'($urandom),
                        ($urandom_range(0, 99) < valid_pct), 8'($urandom));
            exp = {(m_k >= 0), exp_lane(1), exp_lane(2), 8'(m_count), (m_state == M_LOCK),
                   m_key, m_nonce, m_init, (m_state != M_IDLE) || (m_k >= 0), (m_q.size() < DEPTH)};
            act = {pt_valid, plain_text_input1, plain_text_input2, byte_count, lock,
                   key, nonce, init_value, busy, in_ready};
            checks++;
            if (act !== exp) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d got {v,l1,l2,cnt,lock,key,nonce,init,busy,rdy}=%h expected %h",
                         cyc, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_config_load();
        test_single_byte();
        test_back_to_back();
        test_relock();
        test_full_backpressure();
        test_reset_mid_byte();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
